// File: rtl/sel4_rr_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sel4_rr_arbiter_pkg                                       |
// | Purpose  : Shared types and helpers for the 4-way round-robin        |
// |            arbiter: state enum, one-hot conversions, rotating pick.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package sel4_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Callers only pass one-hot or zero vectors, so OR-ing indices is exact.
  function automatic logic [1:0] onehot2idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) r = r | 2'(i);
    end
    return r;
  endfunction

  // First asserted valid at ptr, ptr+1, ... (mod 4). Scanning from the far
  // end lets the nearest candidate overwrite the others.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] valid, input logic [1:0] ptr);
    pick_t      p;
    logic [1:0] idx;
    p = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (valid[idx]) begin
        p.found = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sel4_rr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sel4_rr_arbiter_if                                        |
// | Purpose  : Requester and output handshake bundle of the arbiter.     |
// |            master = arbiter side, slave = requesters / consumer.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface sel4_rr_arbiter_if #(
  parameter int WIDTH = 32
);
  import sel4_rr_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_last;
  logic [WIDTH-1:0]   src0;
  logic [WIDTH-1:0]   src1;
  logic [WIDTH-1:0]   src2;
  logic [WIDTH-1:0]   src3;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] sel;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_src;
  logic               out_last;
  logic               burst_trunc;

  modport master (
    input  req_valid, req_last, src0, src1, src2, src3, out_ready,
    output req_ready, sel, out_valid, out_data, out_src, out_last, burst_trunc
  );

  modport slave (
    output req_valid, req_last, src0, src1, src2, src3, out_ready,
    input  req_ready, sel, out_valid, out_data, out_src, out_last, burst_trunc
  );

endinterface
`default_nettype wire

// File: rtl/sel4_rr_arbiter_mux4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sel_onehot_mux4                                           |
// | Purpose  : Combinational one-hot AND-OR 4:1 selector. A zero select  |
// |            yields zero.                                              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module sel_onehot_mux4 #(
  parameter int WIDTH = 32
) (
  input  wire logic [3:0]       i_sel,
  input  wire logic [WIDTH-1:0] i_d0,
  input  wire logic [WIDTH-1:0] i_d1,
  input  wire logic [WIDTH-1:0] i_d2,
  input  wire logic [WIDTH-1:0] i_d3,
  output logic      [WIDTH-1:0] o_y
);

  // Each lane is masked by its select bit and the lanes are OR-ed together.
  always_comb begin
    o_y = ({WIDTH{i_sel[0]}} & i_d0)
        | ({WIDTH{i_sel[1]}} & i_d1)
        | ({WIDTH{i_sel[2]}} & i_d2)
        | ({WIDTH{i_sel[3]}} & i_d3);
  end

endmodule
`default_nettype wire

// File: rtl/sel4_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sel4_rr_arbiter                                           |
// | Purpose  : Round-robin arbiter with burst lock for a shared one-hot  |
// |            4:1 selector, feeding a one-entry valid/ready register.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module sel4_rr_arbiter
  import sel4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 8
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  sel4_rr_arbiter_if.master     bus
);

  localparam logic [8:0] c_max_burst = 9'(MAX_BURST);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_owner;
  logic [1:0]         w_owner_nxt;
  logic [1:0]         r_ptr;
  logic [1:0]         w_ptr_nxt;
  logic [7:0]         r_beat_cnt;
  logic [7:0]         w_cnt_nxt;

  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [1:0]         r_out_src;
  logic               r_out_last;
  logic               r_burst_trunc;

  pick_t              w_pick;
  logic               w_slot_free;
  logic [NUM_REQ-1:0] w_sel;
  logic [NUM_REQ-1:0] w_ready;
  logic [1:0]         w_gidx;
  logic               w_xfer;
  logic [8:0]         w_cnt_inc;
  logic               w_hit_max;
  logic               w_req_last;
  logic               w_beat_last;
  logic               w_trunc;
  logic [WIDTH-1:0]   w_mux_data;

  // The output slot can take a new word when empty or draining this cycle.
  assign w_slot_free = !r_out_valid || bus.out_ready;

  sel_onehot_mux4 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .i_sel (w_sel),
    .i_d0  (bus.src0),
    .i_d1  (bus.src1),
    .i_d2  (bus.src2),
    .i_d3  (bus.src3),
    .o_y   (w_mux_data)
  );

  // Grant selection, transfer detection and next-state decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_beat_cnt;
    w_sel       = '0;
    w_ready     = '0;
    w_beat_last = 1'b0;
    w_trunc     = 1'b0;
    w_pick      = rr_pick(bus.req_valid, r_ptr);

    case (r_state)
      IDLE: begin
        if (w_pick.found) begin
          w_sel = idx2onehot(w_pick.idx);
          if (w_slot_free) w_ready = w_sel;
        end
      end
      LOCKED: begin
        // The owner keeps the selector even while its valid is low.
        w_sel = idx2onehot(r_owner);
        if (w_slot_free && bus.req_valid[r_owner]) w_ready = w_sel;
      end
      default: ;
    endcase

    // Selector and accept strobes are silenced for the whole reset window.
    if (!reset_n) begin
      w_sel   = '0;
      w_ready = '0;
    end

    w_gidx     = onehot2idx(w_sel);
    w_xfer     = |w_ready;
    w_cnt_inc  = {1'b0, r_beat_cnt} + 9'd1;
    w_hit_max  = (w_cnt_inc == c_max_burst);
    w_req_last = bus.req_last[w_gidx];

    if (w_xfer) begin
      w_beat_last = w_req_last || w_hit_max;
      if (w_beat_last) begin
        w_state_nxt = IDLE;
        w_ptr_nxt   = w_gidx + 2'd1;
        w_cnt_nxt   = '0;
        w_trunc     = w_hit_max && !w_req_last;
      end else begin
        w_state_nxt = LOCKED;
        w_owner_nxt = w_gidx;
        w_cnt_nxt   = w_cnt_inc[7:0];
      end
    end
  end

  // Arbitration state: lock owner, rotation pointer and beat counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_ptr      <= w_ptr_nxt;
      r_beat_cnt <= w_cnt_nxt;
    end
  end

  // One-entry output register; data is held when the slot simply drains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_src     <= '0;
      r_out_last    <= 1'b0;
      r_burst_trunc <= 1'b0;
    end else begin
      r_burst_trunc <= w_trunc;
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux_data;
        r_out_src   <= w_gidx;
        r_out_last  <= w_beat_last;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.sel         = w_sel;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_src     = r_out_src;
  assign bus.out_last    = r_out_last;
  assign bus.burst_trunc = r_burst_trunc;

endmodule
`default_nettype wire

// File: tb/tb_sel4_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_sel4_rr_arbiter                                        |
// | Purpose  : Self-checking bench: cycle model of the arbitration rules |
// |            feeding a scoreboard of expected output words.            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_sel4_rr_arbiter;
  import sel4_rr_arbiter_pkg::*;

  localparam int WIDTH     = 32;
  localparam int MAX_BURST = 8;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  src;
    logic        last;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  exp_t exp_q[$];

  // Model state: owner = -1 means no grant is held.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_cnt   = 0;
  bit m_ovalid = 1'b0;
  bit m_trunc  = 1'b0;

  sel4_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  sel4_rr_arbiter #(
    .WIDTH     (WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] srcword(input int g);
    case (g)
      0: return bus.src0;
      1: return bus.src1;
      2: return bus.src2;
      default: return bus.src3;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic ordy);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.out_ready = ordy;
    bus.src0 = $urandom;
    bus.src1 = $urandom;
    bus.src2 = $urandom;
    bus.src3 = $urandom;
  endtask

  // Reference model: evaluates the rules on settled inputs each cycle.
  always @(negedge clk) begin : p_model
    int         g;
    bit         slot;
    bit         xfer;
    bit         lst;
    bit         hit;
    logic [3:0] esel;
    logic [3:0] erdy;
    exp_t       e;
    if (!reset_n) begin
      m_owner  = -1;
      m_ptr    = 0;
      m_cnt    = 0;
      m_ovalid = 1'b0;
      m_trunc  = 1'b0;
      exp_q.delete();
    end else begin
      slot = !m_ovalid || bus.out_ready;
      g    = m_owner;
      if (m_owner < 0) begin
        for (int k = 0; k < 4; k++) begin
          if (g < 0 && bus.req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
        end
      end
      esel = (g >= 0) ? 4'(1 << g) : 4'b0000;
      xfer = (g >= 0) && slot && bus.req_valid[g];
      erdy = xfer ? esel : 4'b0000;
      chk("sel", bus.sel, esel);
      chk("req_ready", bus.req_ready, erdy);
      chk("out_valid", bus.out_valid, m_ovalid);
      chk("burst_trunc", bus.burst_trunc, m_trunc);
      if (xfer) begin
        lst    = bus.req_last[g];
        hit    = (m_cnt + 1 == MAX_BURST);
        e.data = srcword(g);
        e.src  = 2'(g);
        e.last = lst || hit;
        exp_q.push_back(e);
        m_trunc = hit && !lst;
        if (lst || hit) begin
          m_owner = -1;
          m_ptr   = (g + 1) % 4;
          m_cnt   = 0;
        end else begin
          m_owner = g;
          m_cnt   = m_cnt + 1;
        end
        m_ovalid = 1'b1;
      end else begin
        m_trunc = 1'b0;
        if (slot) m_ovalid = 1'b0;
      end
    end
  end

  // Monitor: every word consumed downstream must match the oldest expectation.
  always @(negedge clk) begin : p_monitor
    exp_t e;
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%0h required=none at %0t", bus.out_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_src", bus.out_src, e.src);
        chk("out_last", bus.out_last, e.last);
      end
    end
  end

  initial begin
    drive(4'hF, 4'hF, 1'b1);
    repeat (3) cyc();
    // Reset state, with all requests asserted to show sel/req_ready gating.
    chk("rst_sel", bus.sel, 4'b0000);
    chk("rst_req_ready", bus.req_ready, 4'b0000);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_out_src", bus.out_src, 2'd0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_burst_trunc", bus.burst_trunc, 1'b0);
    reset_n = 1'b1;

    // Per-beat round robin with every requester valid.
    repeat (8) begin drive(4'hF, 4'hF, 1'b1); cyc(); end

    // Single req0 beat moves the pointer to 1, then a 3-beat req1 burst.
    drive(4'b0001, 4'b0001, 1'b1); cyc();
    drive(4'b0111, 4'b0000, 1'b1); cyc();
    drive(4'b0111, 4'b0000, 1'b1); cyc();
    drive(4'b0111, 4'b0010, 1'b1); cyc();
    drive(4'b0101, 4'b0100, 1'b1); cyc();

    // req3 streams without last alongside req0: forced release at the limit.
    repeat (11) begin drive(4'b1001, 4'b0000, 1'b1); cyc(); end
    drive(4'b1111, 4'b1111, 1'b1); cyc();
    drive(4'b1111, 4'b1111, 1'b1); cyc();

    // Backpressure on a single req0 word.
    drive(4'b0001, 4'b0001, 1'b1); bus.src0 = 32'hDEADBEEF; cyc();
    repeat (5) begin
      drive(4'b0001, 4'b0001, 1'b0); bus.src0 = 32'hDEADBEEF; cyc();
      chk("hold_out_data", bus.out_data, 32'hDEADBEEF);
    end
    drive(4'b0001, 4'b0001, 1'b1); bus.src0 = 32'hDEADBEEF; cyc();

    // req2 locks, goes quiet for 3 cycles while others request, then finishes.
    drive(4'b0100, 4'b0000, 1'b1); cyc();
    drive(4'b0100, 4'b0000, 1'b1); cyc();
    repeat (3) begin drive(4'b1011, 4'b0000, 1'b1); cyc(); end
    drive(4'b0100, 4'b0000, 1'b1); cyc();
    drive(4'b0100, 4'b0100, 1'b1); cyc();

    // Randomized traffic with sparse last flags and random backpressure.
    repeat (400) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom & $urandom & $urandom),
            1'($urandom_range(0, 3) != 0));
      cyc();
    end

    // Close any lock, then start a req1 burst and reset it asynchronously.
    drive(4'hF, 4'hF, 1'b1); cyc();
    drive(4'hF, 4'hF, 1'b1); cyc();
    repeat (3) begin drive(4'b0010, 4'b0000, 1'b1); cyc(); end
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", bus.out_valid, 1'b0);
    chk("async_rst_sel", bus.sel, 4'b0000);
    chk("async_rst_req_ready", bus.req_ready, 4'b0000);
    cyc();
    cyc();
    drive(4'hF, 4'hF, 1'b1);
    reset_n = 1'b1;
    #1;
    chk("post_rst_sel", bus.sel, 4'b0001);
    repeat (6) cyc();

    // Drain whatever is still expected.
    drive(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) cyc();
    cyc();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
